mdu_hilo: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath, directly downstream of the register file read ports.
- Takes RD1/RD2 operands for MULT, MULTU, DIV and DIVU, and computes over 32 cycles.
- Holds results in architectural HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO.
- Exposes a busy/done handshake so the controller can stall dependent instructions.

---
 rtl/mdu_hilo.sv | 162 ++++++++++++++++
 tb/tb_mdu_hilo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Each operation runs one shift-add or restoring shift-subtract step per clock for WIDTH clocks.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               load, step;

    // Datapath state: operands are stored as magnitudes; signs are re-applied at completion.
    logic               is_div_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               dz_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;

    logic               signed_op, a_neg, b_neg;
    logic signed [WIDTH-1:0] sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod_fix;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign sa        = src_a;
    assign sb        = src_b;
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & (sa < 0);
    assign b_neg     = signed_op & (sb < 0);
    assign mag_a     = neg_w(src_a, a_neg);
    assign mag_b     = neg_w(src_b, b_neg);

    // One iteration of either algorithm, plus the sign-corrected final result.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod_fix = neg_2w({step_hi, step_lo}, neg_q_q);
        if (is_div_q) begin
            fin_hi = neg_w(step_hi, neg_r_q);
            fin_lo = dz_q ? '1 : neg_w(step_lo, neg_q_q);
        end else begin
            fin_hi = prod_fix[2*WIDTH-1:WIDTH];
            fin_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = fin_hi;
                    lo_d    = fin_lo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            is_div_q <= op[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dz_q     <= (src_b == '0);
            acc_hi_q <= '0;
            opnd_q   <= op[1] ? mag_b : mag_a;
            acc_lo_q <= op[1] ? mag_a : mag_b;
        end else if (step) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: directed test-plan cases plus random operations
// compared against a plain-arithmetic model of the HI/LO results.
module tb_mdu_hilo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Returns {hi, lo} for an operation, using ordinary 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch at the next edge and follow the operation to its done cycle.
    // Returns at #1 after the completing edge, so a following call starts back-to-back.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit wr_same);
        logic [63:0] r;
        r = model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        if (wr_same) begin hi_we = 1'b1; wd = 32'h5A5A0001; end
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        if (wr_same) begin
            exp_hi = 32'h5A5A0001;
            chk("same_edge_write_hi", hi, exp_hi);
        end
        for (int i = 1; i < 32; i++) begin
            if (i == 10) begin
                start = 1'b1; op = 2'($urandom_range(0, 3));
                src_a = $urandom; src_b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEADBEEF;
            end
            @(posedge clk); #1;
            if (i == 10) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_hi_hold", hi, exp_hi);
            chk("run_lo_hold", lo, exp_lo);
        end
        @(posedge clk); #1;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_hi", hi, exp_hi);
        chk("fin_lo", lo, exp_lo);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_hi", hi, exp_hi);
        chk("idle_lo", lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        exp_hi = '0; exp_lo = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(2'b01, 32'h0000FFFF, 32'h00010001, 1'b0);
        chk("multu_hi_lit", hi, 32'h00000000);
        chk("multu_lo_lit", lo, 32'hFFFFFFFF);
        idle_cycle();

        do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b0);
        chk("mult_hi_lit", hi, 32'hFFFFFFFF);
        chk("mult_lo_lit", lo, 32'hFFFFFFF1);
        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        chk("div_lo_lit", lo, 32'hFFFFFFFD);
        chk("div_hi_lit", hi, 32'hFFFFFFFF);
        do_op(2'b11, 32'h00000064, 32'h00000007, 1'b0);
        chk("divu_lo_lit", lo, 32'h0000000E);
        chk("divu_hi_lit", hi, 32'h00000002);
        do_op(2'b11, 32'h12345678, 32'h00000000, 1'b0);
        chk("divu0_lo_lit", lo, 32'hFFFFFFFF);
        chk("divu0_hi_lit", hi, 32'h12345678);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf_lo_lit", lo, 32'h80000000);
        chk("div_ovf_hi_lit", hi, 32'h00000000);
        do_op(2'b10, 32'h87654321, 32'h00000000, 1'b0);
        idle_cycle();

        hi_we = 1'b1; wd = 32'hCAFEF00D;
        @(posedge clk); #1;
        hi_we = 1'b0;
        exp_hi = 32'hCAFEF00D;
        chk("mthi_hi", hi, exp_hi);
        chk("mthi_done", 32'(done), 32'd0);
        lo_we = 1'b1; wd = 32'h0BADC0DE;
        @(posedge clk); #1;
        lo_we = 1'b0;
        exp_lo = 32'h0BADC0DE;
        chk("mtlo_lo", lo, exp_lo);
        chk("mtlo_hi", hi, exp_hi);
        chk("mtlo_done", 32'(done), 32'd0);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h13572468;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = 32'h13572468; exp_lo = 32'h13572468;
        chk("mtboth_hi", hi, exp_hi);
        chk("mtboth_lo", lo, exp_lo);

        do_op(2'b00, 32'h80000000, 32'h80000000, 1'b1);
        idle_cycle();

        for (int n = 0; n < 16; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            do_op(ro, ra, rb, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        op = 2'b10; src_a = 32'h00001000; src_b = 32'h00000003; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, exp_hi);
        chk("midrst_lo", lo, exp_lo);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        idle_cycle();
        do_op(2'b01, 32'h00000002, 32'h00000003, 1'b0);
        chk("post_rst_lo_lit", lo, 32'h00000006);
        chk("post_rst_hi_lit", hi, 32'h00000000);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
